// File: rtl/sad_search_ctrl_pkg.sv
// Shared definitions for the SAD motion-search sequencer: state encoding,
// per-word SAD bounds, drain length and a counter-width helper.
package sad_search_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_CMP,
    S_FIN
  } state_t;

  // Largest SAD one 4-lane word pair can produce (4 * 255).
  localparam int SAD_WORD_MAX = 1020;
  // Width of the SAD unit result.
  localparam int SAD_W        = $clog2(SAD_WORD_MAX + 1);
  // Cycles between the last read of a candidate and its compare.
  localparam int DRAIN_CYCLES = 2;

  // Counter width for a 0..n-1 counter; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sad_4x8.sv
// 4-lane 8-bit sum of absolute differences: purely combinational,
// result is the sum of |a[i] - b[i]| over the four byte lanes.
module sad_4x8 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [9:0]  sad
);

  logic [7:0] diff [4];

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign diff[i] = (a[8*i +: 8] > b[8*i +: 8]) ? (a[8*i +: 8] - b[8*i +: 8])
                                                 : (b[8*i +: 8] - a[8*i +: 8]);
  end

  assign sad = 10'(diff[0]) + 10'(diff[1]) + 10'(diff[2]) + 10'(diff[3]);

endmodule

// File: rtl/sad_scan_counter.sv
// Nested block (br/bw) and candidate (cr/cc) counters with last-flags.
// Frame addresses are tracked incrementally so no multiplier is needed:
// row_start = address of (cr,0), cand_addr = address of (cr,cc),
// line_addr = cand_addr + br*stride. All address arithmetic wraps.
module sad_scan_counter
  import sad_search_ctrl_pkg::*;
#(
  parameter int BLK_ROWS  = 4,
  parameter int BLK_WORDS = 1,
  parameter int ADDR_W    = 10,
  parameter int POS_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              next_cand,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] stride,
  input  logic [POS_W-1:0]  rows,
  input  logic [POS_W-1:0]  cols,
  output logic [ADDR_W-1:0] t_addr,
  output logic [ADDR_W-1:0] f_addr,
  output logic              blk_last,
  output logic              cand_last,
  output logic [POS_W-1:0]  cr,
  output logic [POS_W-1:0]  cc
);

  localparam int BR_W = cnt_w(BLK_ROWS);
  localparam int BW_W = cnt_w(BLK_WORDS);

  logic [BR_W-1:0]   br;
  logic [BW_W-1:0]   bw;
  logic [POS_W-1:0]  rows_q, cols_q;
  logic [ADDR_W-1:0] stride_q, row_start, cand_addr, line_addr;
  logic              br_last, bw_last, cc_last;

  assign br_last   = (br == BR_W'(BLK_ROWS - 1));
  assign bw_last   = (bw == BW_W'(BLK_WORDS - 1));
  assign cc_last   = (cc == cols_q - POS_W'(1));
  assign blk_last  = br_last && bw_last;
  assign cand_last = cc_last && (cr == rows_q - POS_W'(1));

  assign t_addr = ADDR_W'(br) * ADDR_W'(BLK_WORDS) + ADDR_W'(bw);
  assign f_addr = line_addr + ADDR_W'(bw);

  // Capture the scan geometry on load, then walk block and candidate counters.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      br        <= '0;
      bw        <= '0;
      cr        <= '0;
      cc        <= '0;
      rows_q    <= '0;
      cols_q    <= '0;
      stride_q  <= '0;
      row_start <= '0;
      cand_addr <= '0;
      line_addr <= '0;
    end else if (load) begin
      br        <= '0;
      bw        <= '0;
      cr        <= '0;
      cc        <= '0;
      rows_q    <= rows;
      cols_q    <= cols;
      stride_q  <= stride;
      row_start <= base;
      cand_addr <= base;
      line_addr <= base;
    end else if (step) begin
      if (bw_last) begin
        bw <= '0;
        if (br_last) begin
          br        <= '0;
          line_addr <= cand_addr;
        end else begin
          br        <= br + BR_W'(1);
          line_addr <= line_addr + stride_q;
        end
      end else begin
        bw <= bw + BW_W'(1);
      end
    end else if (next_cand) begin
      if (cc_last) begin
        cc        <= '0;
        cr        <= cr + POS_W'(1);
        row_start <= row_start + stride_q;
        cand_addr <= row_start + stride_q;
        line_addr <= row_start + stride_q;
      end else begin
        cc        <= cc + POS_W'(1);
        cand_addr <= cand_addr + ADDR_W'(1);
        line_addr <= cand_addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/sad_search_ctrl.sv
// Block motion-search sequencer: scans candidate positions, feeds template
// and frame words to a 4-lane SAD unit, accumulates per candidate and keeps
// the first minimum in raster order.
module sad_search_ctrl
  import sad_search_ctrl_pkg::*;
#(
  parameter int BLK_ROWS  = 4,
  parameter int BLK_WORDS = 1,
  parameter int ADDR_W    = 10,
  parameter int ACC_W     = 16,
  parameter int POS_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] frame_base,
  input  logic [ADDR_W-1:0] frame_stride,
  input  logic [POS_W-1:0]  cand_rows,
  input  logic [POS_W-1:0]  cand_cols,
  output logic [ADDR_W-1:0] t_addr,
  output logic [ADDR_W-1:0] f_addr,
  output logic              rd_en,
  input  logic [31:0]       t_data,
  input  logic [31:0]       f_data,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  min_sad,
  output logic [POS_W-1:0]  min_row,
  output logic [POS_W-1:0]  min_col
);

  localparam int DC_W = cnt_w(DRAIN_CYCLES);

  state_t             state;
  logic [DC_W-1:0]    drain_cnt;
  logic               accept, step, next_cand;
  logic               blk_last, cand_last;
  logic [POS_W-1:0]   cr, cc;
  logic [SAD_W-1:0]   sad_w, sad_q;
  logic               data_vld, sad_vld;
  logic [ACC_W-1:0]   acc;

  assign accept    = (state == S_IDLE) && start;
  assign step      = (state == S_ISSUE);
  assign next_cand = (state == S_CMP);

  sad_scan_counter #(
    .BLK_ROWS  (BLK_ROWS),
    .BLK_WORDS (BLK_WORDS),
    .ADDR_W    (ADDR_W),
    .POS_W     (POS_W)
  ) u_scan (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .step      (step),
    .next_cand (next_cand),
    .base      (frame_base),
    .stride    (frame_stride),
    .rows      (cand_rows),
    .cols      (cand_cols),
    .t_addr    (t_addr),
    .f_addr    (f_addr),
    .blk_last  (blk_last),
    .cand_last (cand_last),
    .cr        (cr),
    .cc        (cc)
  );

  sad_4x8 u_sad (
    .a   (t_data),
    .b   (f_data),
    .sad (sad_w)
  );

  // Pipeline: read data valid one cycle after rd_en, SAD result registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_vld <= 1'b0;
      sad_vld  <= 1'b0;
      sad_q    <= '0;
    end else begin
      data_vld <= rd_en;
      sad_vld  <= data_vld;
      sad_q    <= sad_w;
    end
  end

  // Per-candidate accumulator; cleared on launch and at each compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (accept || next_cand) begin
      acc <= '0;
    end else if (sad_vld) begin
      acc <= acc + ACC_W'(sad_q);
    end
  end

  // Sequencer FSM with registered outputs and minimum tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      drain_cnt <= '0;
      rd_en     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      min_sad   <= '0;
      min_row   <= '0;
      min_col   <= '0;
    end else begin
      // NOTE: done is defaulted low every cycle so it can only ever be a
      // single-cycle pulse, whatever branch the case takes.
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            min_sad <= '1;
            min_row <= '0;
            min_col <= '0;
            if (cand_rows == '0 || cand_cols == '0) begin
              state <= S_FIN;
            end else begin
              state <= S_ISSUE;
              rd_en <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (blk_last) begin
            state     <= S_DRAIN;
            rd_en     <= 1'b0;
            drain_cnt <= '0;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DC_W'(DRAIN_CYCLES - 1)) begin
            state <= S_CMP;
          end else begin
            drain_cnt <= drain_cnt + DC_W'(1);
          end
        end
        S_CMP: begin
          if (acc < min_sad) begin
            min_sad <= acc;
            min_row <= cr;
            min_col <= cc;
          end
          if (cand_last) begin
            state <= S_FIN;
          end else begin
            state <= S_ISSUE;
            rd_en <= 1'b1;
          end
        end
        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          rd_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Self-checking bench for sad_search_ctrl: directed scenarios plus random
// searches, each compared against a behavioural full-search model.
module tb_sad_search_ctrl;

  localparam int BLK_ROWS  = 4;
  localparam int BLK_WORDS = 1;
  localparam int N         = BLK_ROWS * BLK_WORDS;
  localparam int ADDR_W    = 10;
  localparam int ACC_W     = 16;
  localparam int POS_W     = 8;
  localparam int MEM_SZ    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] frame_base, frame_stride;
  logic [POS_W-1:0]  cand_rows, cand_cols;
  logic [ADDR_W-1:0] t_addr, f_addr;
  logic              rd_en;
  logic [31:0]       t_data, f_data;
  logic              busy, done;
  logic [ACC_W-1:0]  min_sad;
  logic [POS_W-1:0]  min_row, min_col;

  sad_search_ctrl #(
    .BLK_ROWS  (BLK_ROWS),
    .BLK_WORDS (BLK_WORDS),
    .ADDR_W    (ADDR_W),
    .ACC_W     (ACC_W),
    .POS_W     (POS_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .frame_base   (frame_base),
    .frame_stride (frame_stride),
    .cand_rows    (cand_rows),
    .cand_cols    (cand_cols),
    .t_addr       (t_addr),
    .f_addr       (f_addr),
    .rd_en        (rd_en),
    .t_data       (t_data),
    .f_data       (f_data),
    .busy         (busy),
    .done         (done),
    .min_sad      (min_sad),
    .min_row      (min_row),
    .min_col      (min_col)
  );

  always #5 clk = ~clk;

  // Synchronous-read template and frame memories.
  logic [31:0] tmem [MEM_SZ];
  logic [31:0] fmem [MEM_SZ];

  always @(posedge clk) begin
    if (rd_en) begin
      t_data <= tmem[t_addr];
      f_data <= fmem[f_addr];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected read sequence, consumed by the read monitor.
  typedef struct {
    logic [ADDR_W-1:0] t;
    logic [ADDR_W-1:0] f;
  } rd_t;

  rd_t               exp_q [$];
  logic [ADDR_W-1:0] obs_f [$];
  int                rd_cnt   = 0;
  int                done_cnt = 0;
  bit                mon_en   = 1'b0;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (!rst && mon_en && rd_en) begin
      rd_cnt++;
      obs_f.push_back(f_addr);
      if (exp_q.size() > 0) begin
        rd_t e;
        e = exp_q.pop_front();
        check("t_addr", t_addr, e.t);
        check("f_addr", f_addr, e.f);
      end
    end
  end

  function automatic int word_sad(input logic [31:0] a, input logic [31:0] b);
    int s = 0;
    for (int i = 0; i < 4; i++) begin
      int x, y;
      x = int'(a[8*i +: 8]);
      y = int'(b[8*i +: 8]);
      s += (x > y) ? (x - y) : (y - x);
    end
    return s;
  endfunction

  // Launch one search, compare result, timing and read traffic with the model.
  task automatic run_search(input string tag, input int base, input int stride,
                            input int rows, input int cols, input bit mid_start);
    int  exp_sad, exp_r, exp_c, exp_cyc, exp_rd, n;
    bit  seen;
    rd_t e;

    exp_q.delete();
    obs_f.delete();
    exp_sad = (1 << ACC_W) - 1;
    exp_r   = 0;
    exp_c   = 0;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        int s = 0;
        for (int br = 0; br < BLK_ROWS; br++) begin
          for (int bw = 0; bw < BLK_WORDS; bw++) begin
            e.t = ADDR_W'(br * BLK_WORDS + bw);
            e.f = ADDR_W'((base + (r + br) * stride + c + bw) % MEM_SZ);
            exp_q.push_back(e);
            s += word_sad(tmem[e.t], fmem[e.f]);
          end
        end
        if (s < exp_sad) begin
          exp_sad = s;
          exp_r   = r;
          exp_c   = c;
        end
      end
    end
    exp_rd  = rows * cols * N;
    exp_cyc = rows * cols * (N + 3) + 2;
    rd_cnt  = 0;
    mon_en  = 1'b1;

    @(negedge clk);
    frame_base   = ADDR_W'(base);
    frame_stride = ADDR_W'(stride);
    cand_rows    = POS_W'(rows);
    cand_cols    = POS_W'(cols);
    start        = 1'b1;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < exp_cyc + 20) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        start = 1'b0;
        check({tag, "_busy"}, busy, 1'b1);
      end
      if (mid_start && n == 5) begin
        start        = 1'b1;
        frame_base   = ~ADDR_W'(base);
        cand_rows    = POS_W'(rows + 1);
        cand_cols    = POS_W'(cols + 2);
      end
      if (mid_start && n == 6) start = 1'b0;
      if (done) seen = 1'b1;
    end
    check({tag, "_cycles"},  n, exp_cyc);
    check({tag, "_min_sad"}, min_sad, exp_sad);
    check({tag, "_min_row"}, min_row, exp_r);
    check({tag, "_min_col"}, min_col, exp_c);
    check({tag, "_busy_end"}, busy, 1'b0);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_rd_count"}, rd_cnt, exp_rd);
    check({tag, "_rd_left"}, exp_q.size(), 0);
    mon_en = 1'b0;
  endtask

  initial begin
    int dc0;

    rst          = 1'b1;
    start        = 1'b0;
    frame_base   = '0;
    frame_stride = '0;
    cand_rows    = '0;
    cand_cols    = '0;
    for (int i = 0; i < MEM_SZ; i++) begin
      tmem[i] = '0;
      fmem[i] = '0;
    end

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rd_en", rd_en, 1'b0);
    check("rst_min_sad", min_sad, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single candidate, uniform difference of 4 per byte.
    for (int i = 0; i < N; i++) tmem[i] = 32'h0101_0101;
    for (int i = 0; i < MEM_SZ; i++) fmem[i] = 32'h0505_0505;
    run_search("t1", 0, 4, 1, 1, 1'b0);
    check("t1_sad_64", min_sad, 64);

    // 2: exact match at (1,2) against an all-0xFF frame.
    for (int i = 0; i < N; i++) tmem[i] = '0;
    for (int i = 0; i < MEM_SZ; i++) fmem[i] = 32'hFFFF_FFFF;
    for (int br = 0; br < BLK_ROWS; br++) fmem[16 + (1 + br) * 8 + 2] = '0;
    run_search("t2", 16, 8, 2, 3, 1'b0);
    check("t2_sad_0", min_sad, 0);
    check("t2_row_1", min_row, 1);
    check("t2_col_2", min_col, 2);

    // 3: every candidate ties at 40 -> first one wins.
    for (int i = 0; i < MEM_SZ; i++) fmem[i] = 32'h0102_0304;
    run_search("t3", 100, 10, 3, 3, 1'b0);
    check("t3_sad_40", min_sad, 40);
    check("t3_row_0", min_row, 0);
    check("t3_col_0", min_col, 0);

    // 4: zero columns -> immediate finish, no reads.
    run_search("t4", 0, 4, 3, 0, 1'b0);
    check("t4_sad_ones", min_sad, 16'hFFFF);

    // 5: reset mid-ISSUE abandons the scan; a fresh run is correct.
    for (int i = 0; i < N; i++) tmem[i] = $urandom;
    for (int i = 0; i < MEM_SZ; i++) fmem[i] = $urandom;
    dc0 = done_cnt;
    @(negedge clk);
    frame_base   = 10'd40;
    frame_stride = 10'd12;
    cand_rows    = 8'd2;
    cand_cols    = 8'd2;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t5_in_issue", rd_en, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_rd_en", rd_en, 1'b0);
    check("t5_rst_min_sad", min_sad, 0);
    check("t5_rst_t_addr", t_addr, 0);
    check("t5_rst_f_addr", f_addr, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_search("t5", 40, 12, 2, 2, 1'b0);
    check("t5_one_done", done_cnt - dc0, 1);

    // 6: frame address wrap, with a start pulse while busy ignored.
    run_search("t6", 10'h3FE, 4, 2, 2, 1'b1);
    if (obs_f.size() >= 9) begin
      check("t6_wrap_r1", obs_f[1], 10'h002);
      check("t6_c1_r0",   obs_f[4], 10'h3FF);
      check("t6_c2_r0",   obs_f[8], 10'h002);
    end else begin
      check("t6_obs_count", obs_f.size(), 9);
    end

    // Random searches with random geometry and data.
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) tmem[i] = $urandom;
      for (int i = 0; i < MEM_SZ; i++) fmem[i] = $urandom;
      run_search($sformatf("rnd%0d", k), int'($urandom_range(0, MEM_SZ - 1)),
                 int'($urandom_range(1, 64)), int'($urandom_range(1, 5)),
                 int'($urandom_range(1, 5)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
